// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, stall encoding and reset vector for the fetch stage
package inst_fetch_pkg;

  localparam int STALL_BUS_W = 6;
  localparam logic STOP = 1'b1;
  localparam int BR_WD = 33;

  // The fetch/decode bus gains an address-error flag bit when the check is built in.
`ifdef INST_FETCH_ADEL_EN
  localparam int IF_TO_ID_WD = 34;
`else
  localparam int IF_TO_ID_WD = 33;
`endif

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  typedef enum logic {
    FS_RESET = 1'b0,
    FS_RUN   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/branch_hold_buf.sv
// rtl/branch_hold_buf.sv - keeps a branch target seen while fetch is stalled and
// merges it with the live branch into one redirect request.
module branch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall_pc,
  input  logic        i_br_e,
  input  logic [31:0] i_br_addr,
  output logic        o_redirect_e,
  output logic [31:0] o_redirect_addr
);

  logic        r_hold_valid;
  logic [31:0] r_hold_addr;

  // Newest branch during a stall wins; any unstalled cycle consumes or drops the hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= 32'b0;
    end else if (!i_stall_pc) begin
      r_hold_valid <= 1'b0;
    end else if (i_br_e) begin
      r_hold_valid <= 1'b1;
      r_hold_addr  <= i_br_addr;
    end
  end

  assign o_redirect_e    = i_br_e | r_hold_valid;
  assign o_redirect_addr = i_br_e ? i_br_addr : r_hold_addr;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS IF stage: PC register, instruction SRAM request, fetch/decode bus.
// Optional misaligned-fetch flag on the bus when INST_FETCH_ADEL_EN is defined.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_BUS_W-1:0] stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  logic [31:0]  w_redirect_addr;
  logic         w_redirect_e;
  logic         w_stall_pc;
  logic         w_ce;
  logic         w_unused_stall;

  assign w_stall_pc     = (stall[0] == STOP);
  assign w_unused_stall = ^stall[STALL_BUS_W-1:1];

  branch_hold_buf u_branch_hold_buf (
    .clk             (clk),
    .rst             (rst),
    .i_stall_pc      (w_stall_pc),
    .i_br_e          (br_bus[32]),
    .i_br_addr       (br_bus[31:0]),
    .o_redirect_e    (w_redirect_e),
    .o_redirect_addr (w_redirect_addr)
  );

  assign w_next_pc = w_redirect_e ? w_redirect_addr : (r_pc + PC_STEP);

  // Reset one step behind the vector so the first unstalled edge lands on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VECTOR - PC_STEP;
    end else if (!w_stall_pc) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FS_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ce         = 1'b0;
    case (r_state)
      FS_RESET: begin
        if (!w_stall_pc) begin
          w_state_next = FS_RUN;
        end
      end
      FS_RUN: begin
        w_ce = 1'b1;
      end
      default: w_state_next = FS_RESET;
    endcase
  end

`ifdef INST_FETCH_ADEL_EN
  logic w_adel;
  assign w_adel       = w_ce & (r_pc[1:0] != 2'b00);
  assign inst_sram_en = w_ce & ~w_adel;
  assign if_to_id_bus = {w_adel, w_ce, r_pc};
`else
  assign inst_sram_en = w_ce;
  assign if_to_id_bus = {w_ce, r_pc};
`endif

  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed plus randomized bench for inst_fetch against a behavioural model
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic                   clk;
  logic                   rst;
  logic [STALL_BUS_W-1:0] stall;
  logic [BR_WD-1:0]       br_bus;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current fetch address, whether fetching has begun, and branches waiting out a stall.
  logic [31:0] m_pc;
  logic        m_started;
  logic [31:0] m_waiting[$];
  logic        m_valid = 1'b0;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_adel();
`ifdef INST_FETCH_ADEL_EN
    return m_started && (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input logic r, input logic s0, input logic be, input logic [31:0] ba);
    if (r) begin
      m_pc      = RV - 32'd4;
      m_started = 1'b0;
      m_waiting.delete();
    end else if (!s0) begin
      if (be)                        m_pc = ba;
      else if (m_waiting.size() > 0) m_pc = m_waiting[$];
      else                           m_pc = m_pc + 32'd4;
      m_started = 1'b1;
      m_waiting.delete();
    end else if (be) begin
      m_waiting.push_back(ba);
    end
    m_valid = 1'b1;
  endtask

  task automatic cyc(input logic r, input logic s0, input logic be, input logic [31:0] ba);
    logic [STALL_BUS_W-1:0] st;
    st     = {STALL_BUS_W{1'b0}};
    st[0]  = s0;
    st[1]  = s0 ? 1'($urandom_range(0, 1)) : 1'b0;
    rst    = r;
    stall  = st;
    br_bus = {be, ba};
    @(posedge clk);
    model_step(r, s0, be, ba);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("sram_addr", inst_sram_addr, m_pc);
      check("sram_en", 32'(inst_sram_en), 32'(m_started & ~model_adel()));
      check("bus_pc", if_to_id_bus[31:0], m_pc);
      check("bus_ce", 32'(if_to_id_bus[32]), 32'(m_started));
`ifdef INST_FETCH_ADEL_EN
      check("bus_adel", 32'(if_to_id_bus[33]), 32'(model_adel()));
`endif
      check("sram_wen", 32'(inst_sram_wen), 32'd0);
      check("sram_wdata", inst_sram_wdata, 32'd0);
    end
  end

  initial begin
    rst    = 1'b1;
    stall  = '0;
    br_bus = '0;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_addr", inst_sram_addr, 32'hBFBF_FFFC);
    check("rst_en", 32'(inst_sram_en), 32'd0);
    check("rst_ce", 32'(if_to_id_bus[32]), 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("first_addr", inst_sram_addr, 32'hBFC0_0000);
    check("first_en", 32'(inst_sram_en), 32'd1);
    check("first_bus", if_to_id_bus[31:0], 32'hBFC0_0000);
    check("first_ce", 32'(if_to_id_bus[32]), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("second_addr", inst_sram_addr, 32'hBFC0_0004);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("at_0010", inst_sram_addr, 32'hBFC0_0010);

    cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0100);
    check("br_target", inst_sram_addr, 32'hBFC0_0100);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("br_plus4", inst_sram_addr, 32'hBFC0_0104);

    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'hBFC0_0200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("stall_frozen", inst_sram_addr, 32'hBFC0_0104);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("held_target", inst_sram_addr, 32'hBFC0_0200);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_cleared", inst_sram_addr, 32'hBFC0_0204);

    cyc(1'b0, 1'b1, 1'b1, 32'hBFC0_0300);
    cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0400);
    check("override", inst_sram_addr, 32'hBFC0_0400);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("override_next", inst_sram_addr, 32'hBFC0_0404);

    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_top", inst_sram_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_zero", inst_sram_addr, 32'h0000_0000);

    cyc(1'b0, 1'b1, 1'b1, 32'hBFC0_0500);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("midrst_en", 32'(inst_sram_en), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("midrst_restart", inst_sram_addr, 32'hBFC0_0000);

`ifdef INST_FETCH_ADEL_EN
    cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0102);
    check("adel_flag", 32'(if_to_id_bus[33]), 32'd1);
    check("adel_en", 32'(inst_sram_en), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("adel_next", inst_sram_addr, 32'hBFC0_0106);
    check("adel_still", 32'(if_to_id_bus[33]), 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic        r, s0, be;
      logic [31:0] ba;
      r  = ($urandom_range(0, 63) == 0);
      s0 = ($urandom_range(0, 9) < 3);
      be = ($urandom_range(0, 3) == 0);
      ba = $urandom;
      if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
      cyc(r, s0, be, ba);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
